// File: rtl/fifo_burst_reader_if.sv
// Handshake bundle between the burst reader, the FIFO read port and the outbound stream.
// master = burst reader side; slave = FIFO/sink side.
interface fifo_burst_reader_if #(
  parameter int DSIZE = 8
);
  logic             fifo_rempty;
  logic             fifo_rd;
  logic [DSIZE-1:0] fifo_rdata;
  logic             m_valid;
  logic             m_ready;
  logic [DSIZE-1:0] m_data;

  modport master (
    input  fifo_rempty, fifo_rdata, m_ready,
    output fifo_rd, m_valid, m_data
  );

  modport slave (
    output fifo_rempty, fifo_rdata, m_ready,
    input  fifo_rd, m_valid, m_data
  );
endinterface

// File: rtl/fifo_burst_reader.sv
// Drains a programmed number of words from the FIFO read port into a 2-entry
// skid buffer and re-issues them on a valid/ready stream.
module fifo_burst_reader #(
  parameter int DSIZE = 8,
  parameter int CSIZE = 8
) (
  input  logic                 rclk,
  input  logic                 rrst,
  input  logic                 start,
  input  logic [CSIZE-1:0]     burst_len,
  fifo_burst_reader_if.master  bus,
  output logic                 busy,
  output logic                 done,
  output logic [CSIZE-1:0]     xfer_cnt
);

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [CSIZE-1:0] r_len;
  logic [CSIZE-1:0] r_pop_cnt;
  logic [CSIZE-1:0] r_xfer_cnt;
  logic [1:0]       r_occ;
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic             r_done;
  logic [DSIZE-1:0] w_entry [2];

  logic             w_push;
  logic             w_pop;
  logic             w_last;
  logic             w_accept;
  logic             w_zero_start;

  assign w_pop  = bus.m_valid & bus.m_ready;
  assign w_push = bus.fifo_rd;

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_zero_start = 1'b0;
    w_last       = 1'b0;
    bus.fifo_rd  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          if (burst_len != '0) begin
            w_accept     = 1'b1;
            w_state_next = ST_RUN;
          end else begin
            w_zero_start = 1'b1;
          end
        end
      end
      ST_RUN: begin
        // Push only into a free slot; a same-cycle retire does not count as free.
        bus.fifo_rd = !bus.fifo_rempty && (r_pop_cnt < r_len) && (r_occ != 2'd2);
        w_last      = w_pop && ((r_xfer_cnt + CSIZE'(1)) == r_len);
        if (w_last) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge rclk) begin
    if (rrst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge rclk) begin
    if (rrst) begin
      r_len      <= '0;
      r_pop_cnt  <= '0;
      r_xfer_cnt <= '0;
      r_occ      <= '0;
      r_wr_ptr   <= 1'b0;
      r_rd_ptr   <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= w_zero_start | w_last;
      if (w_accept) begin
        r_len      <= burst_len;
        r_pop_cnt  <= '0;
        r_xfer_cnt <= '0;
      end else if (w_zero_start) begin
        r_xfer_cnt <= '0;
      end else begin
        if (w_push) r_pop_cnt  <= r_pop_cnt + CSIZE'(1);
        if (w_pop)  r_xfer_cnt <= r_xfer_cnt + CSIZE'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + 2'd1;
        2'b01:   r_occ <= r_occ - 2'd1;
        default: r_occ <= r_occ;
      endcase
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
    end
  end

  // Buffer slots form a 2-deep ring indexed by the write/read pointers.
  for (genvar gi = 0; gi < 2; gi++) begin : g_buf
    logic [DSIZE-1:0] r_entry;
    always_ff @(posedge rclk) begin
      if (rrst) begin
        r_entry <= '0;
      end else if (w_push && (r_wr_ptr == 1'(gi))) begin
        r_entry <= bus.fifo_rdata;
      end
    end
    assign w_entry[gi] = r_entry;
  end

  assign bus.m_valid = (r_occ != 2'd0);
  assign bus.m_data  = w_entry[r_rd_ptr];
  assign busy        = (r_state == ST_RUN);
  assign done        = r_done;
  assign xfer_cnt    = r_xfer_cnt;

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Scoreboard bench for fifo_burst_reader: a simple FIFO model feeds the reader,
// expected words are queued at start and retired on each stream handshake.
module tb_fifo_burst_reader;

  logic       rclk;
  logic       rrst;
  logic       start;
  logic [7:0] burst_len;
  logic       busy;
  logic       done;
  logic [7:0] xfer_cnt;

  fifo_burst_reader_if #(.DSIZE(8)) bus ();

  fifo_burst_reader #(.DSIZE(8), .CSIZE(8)) dut (
    .rclk      (rclk),
    .rrst      (rrst),
    .start     (start),
    .burst_len (burst_len),
    .bus       (bus.master),
    .busy      (busy),
    .done      (done),
    .xfer_cnt  (xfer_cnt)
  );

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // FIFO model: combinational head, pointer advanced on each pop strobe.
  logic [7:0] mem [64];
  int         wr_ptr = 0;
  int         rd_ptr = 0;
  int         pops   = 0;
  int         cyc    = 0;
  bit         force_empty = 1'b0;
  bit         flush = 1'b0;

  assign bus.fifo_rempty = force_empty || (rd_ptr == wr_ptr);
  assign bus.fifo_rdata  = mem[rd_ptr[5:0]];

  always @(posedge rclk) begin
    cyc++;
    if (flush) begin
      rd_ptr <= wr_ptr;
    end else if (bus.fifo_rd) begin
      rd_ptr <= rd_ptr + 1;
      pops++;
    end
  end

  logic [7:0] exp_q[$];
  bit         prev_stall = 1'b0;
  logic [7:0] prev_data;
  int         last_hs_cyc = 0;

  always @(negedge rclk) begin
    if (!rrst) begin
      check_eq("no_rd_when_empty", bus.fifo_rd & bus.fifo_rempty, 0);
      if (prev_stall) begin
        check_eq("hold_valid", bus.m_valid, 1);
        check_eq("hold_data", bus.m_data, prev_data);
      end
      if (bus.m_valid && bus.m_ready) begin
        if (exp_q.size() == 0) begin
          check_eq("extra_word", bus.m_data, 32'hDEAD);
        end else begin
          check_eq("data", bus.m_data, exp_q.pop_front());
        end
        last_hs_cyc = cyc;
        $display("xfer cyc=%0d data=0x%02h", cyc, bus.m_data);
      end
      prev_stall = bus.m_valid && !bus.m_ready;
      prev_data  = bus.m_data;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic tick();
    @(posedge rclk);
    #2;
  endtask

  task automatic load(input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      mem[wr_ptr[5:0]] = first + 8'(i);
      wr_ptr = wr_ptr + 1;
    end
  endtask

  // Queue the next n words the FIFO will hand out, counted from its current head.
  task automatic expect_words(input int n);
    for (int i = 0; i < n; i++) begin
      int idx;
      idx = rd_ptr + i;
      exp_q.push_back(mem[idx[5:0]]);
    end
  endtask

  task automatic wait_done(input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    check_eq("done_seen", seen, 1);
    if (seen) check_eq("done_after_hs", cyc - last_hs_cyc, 1);
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  int p0;

  initial begin
    rrst = 1'b1;
    start = 1'b0;
    burst_len = '0;
    bus.m_ready = 1'b1;

    // Reset held with start and ready asserted and data in the FIFO.
    tick();
    load(8'h11, 4);
    start = 1'b1;
    burst_len = 8'd4;
    tick();
    tick();
    check_eq("rst_fifo_rd", bus.fifo_rd, 0);
    check_eq("rst_m_valid", bus.m_valid, 0);
    check_eq("rst_m_data", bus.m_data, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_xfer_cnt", xfer_cnt, 0);
    check_eq("rst_pops", pops, 0);
    rrst = 1'b0;
    start = 1'b0;
    tick();

    // Burst of 4, no stalls.
    p0 = pops;
    start = 1'b1;
    burst_len = 8'd4;
    expect_words(4);
    tick();
    start = 1'b0;
    check_eq("b4_busy_c1", busy, 1);
    check_eq("b4_valid_c1", bus.m_valid, 0);
    tick();
    check_eq("b4_valid_c2", bus.m_valid, 1);
    check_eq("b4_data_c2", bus.m_data, 8'h11);
    tick();
    tick();
    tick();
    check_eq("b4_done_c5", done, 0);
    tick();
    check_eq("b4_done_c6", done, 1);
    check_eq("b4_busy_c6", busy, 0);
    check_eq("b4_xfer_cnt", xfer_cnt, 4);
    check_eq("b4_pops", pops - p0, 4);
    tick();
    check_eq("b4_done_pulse", done, 0);
    check_eq("b4_xfer_hold", xfer_cnt, 4);

    // Burst of 3 from a 6-word FIFO with the sink stalled in cycles 2-6.
    load(8'h11, 6);
    p0 = pops;
    bus.m_ready = 1'b0;
    start = 1'b1;
    burst_len = 8'd3;
    expect_words(3);
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    check_eq("stall_valid", bus.m_valid, 1);
    check_eq("stall_data", bus.m_data, 8'h11);
    tick();
    tick();
    check_eq("stall_pops", pops - p0, 2);
    tick();
    bus.m_ready = 1'b1;
    wait_done(20);
    check_eq("stall_total_pops", pops - p0, 3);
    check_eq("stall_fifo_left", wr_ptr - rd_ptr, 3);
    check_eq("stall_sb_empty", exp_q.size(), 0);
    do_flush();

    // FIFO empty for 5 cycles after start.
    force_empty = 1'b1;
    load(8'h21, 2);
    p0 = pops;
    start = 1'b1;
    burst_len = 8'd2;
    expect_words(2);
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check_eq("empty_no_pop", pops - p0, 0);
    force_empty = 1'b0;
    wait_done(20);
    check_eq("empty_pops", pops - p0, 2);
    check_eq("empty_xfer_cnt", xfer_cnt, 2);
    check_eq("empty_sb_empty", exp_q.size(), 0);

    // Zero-length burst, then a start during RUN that must be ignored.
    load(8'h31, 3);
    p0 = pops;
    start = 1'b1;
    burst_len = 8'd0;
    tick();
    start = 1'b0;
    check_eq("zero_done", done, 1);
    check_eq("zero_busy", busy, 0);
    check_eq("zero_xfer_cnt", xfer_cnt, 0);
    tick();
    check_eq("zero_done_pulse", done, 0);
    check_eq("zero_busy_c2", busy, 0);
    check_eq("zero_pops", pops - p0, 0);
    bus.m_ready = 1'b0;
    start = 1'b1;
    burst_len = 8'd2;
    expect_words(2);
    tick();
    start = 1'b0;
    check_eq("ign_busy", busy, 1);
    tick();
    start = 1'b1;
    burst_len = 8'd3;
    tick();
    start = 1'b0;
    check_eq("ign_busy_after", busy, 1);
    bus.m_ready = 1'b1;
    wait_done(20);
    check_eq("ign_xfer_cnt", xfer_cnt, 2);
    check_eq("ign_pops", pops - p0, 2);
    check_eq("ign_fifo_left", wr_ptr - rd_ptr, 1);
    do_flush();

    // Reset mid-burst with the buffer full.
    load(8'h41, 5);
    p0 = pops;
    bus.m_ready = 1'b0;
    start = 1'b1;
    burst_len = 8'd5;
    expect_words(5);
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check_eq("mid_pops", pops - p0, 2);
    check_eq("mid_busy", busy, 1);
    rrst = 1'b1;
    flush = 1'b1;
    exp_q.delete();
    tick();
    check_eq("mid_rst_valid", bus.m_valid, 0);
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_xfer_cnt", xfer_cnt, 0);
    rrst = 1'b0;
    flush = 1'b0;
    bus.m_ready = 1'b1;
    tick();
    load(8'h51, 3);
    p0 = pops;
    start = 1'b1;
    burst_len = 8'd3;
    expect_words(3);
    tick();
    start = 1'b0;
    check_eq("post_rst_busy", busy, 1);
    wait_done(20);
    check_eq("post_rst_xfer_cnt", xfer_cnt, 3);
    check_eq("post_rst_pops", pops - p0, 3);
    check_eq("post_rst_sb_empty", exp_q.size(), 0);

    tick();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=%0d exp=finish", cyc);
    $fatal(1, "timeout");
  end

endmodule
